// File: rtl/bit_serial_add_seq.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first,
// recirculates its carry and assembles a WIDTH-bit sum with start/busy/done handshake.
module bit_serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_sh_s;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  // Next-state decode and the incoming sum bit merged into the shift register
  always_comb begin
    state_s  = state_r;
    sum_sh_s = {fa_sum, sum_sh_r[WIDTH-1:1]};
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == LAST_BIT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_SHIFT);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand capture, bit shifting, carry recirculation and result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r  <= op_a;
            b_sh_r  <= op_b;
            carry_r <= cin;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          sum_sh_r <= sum_sh_s;
          carry_r  <= fa_carry;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
            sum_r  <= sum_sh_s;
            cout_r <= fa_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Adder inputs are forced low outside SHIFT so IDLE/DONE never toggle the cell
  assign fa_a   = busy_r & a_sh_r[0];
  assign fa_b   = busy_r & b_sh_r[0];
  assign fa_cin = busy_r & carry_r;

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_bit_serial_add_seq.sv
// Directed and back-to-back random checks of bit_serial_add_seq with a
// behavioural full adder closing the loop on the fa_* ports.
module tb_bit_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_sum;
  logic       fa_carry;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int errors = 0;
  int checks = 0;

  bit_serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_carry(fa_carry),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Pulses start for one op and returns the cycle (1 = first after start edge) done rose
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat);
    @(posedge clk); #1;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
    #12;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({fa_a, fa_b, fa_cin, busy} !== 4'd0) begin
      errors++;
      $display("FAIL idle_fa_ports: fa_a=%b fa_b=%b fa_cin=%b busy=%b, required 0", fa_a, fa_b, fa_cin, busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [6] = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'hAA};
    logic [7:0] vb [6] = '{8'h3C, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h55};
    logic       vc [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [7:0] es [6] = '{8'h96, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00};
    logic       ec [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], lat);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL basic_latency[%0d]: done at cycle %0d, required 9", i, lat);
      end
      checks++;
      if (sum !== es[i] || cout !== ec[i]) begin
        errors++;
        $display("FAIL basic_result[%0d]: sum=%h cout=%b, required sum=%h cout=%b", i, sum, cout, es[i], ec[i]);
      end
      checks++;
      if ({busy, fa_a, fa_b, fa_cin} !== 4'd0) begin
        errors++;
        $display("FAIL basic_done_quiet[%0d]: busy=%b fa=%b%b%b, required 0", i, busy, fa_a, fa_b, fa_cin);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [7:0] got_sum = 8'h00;
    logic       got_cout = 1'b1;
    @(posedge clk); #1;
    op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin
        op_a = 8'hEE; op_b = 8'hEE; cin = 1'b1; start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        got_sum  = sum;
        got_cout = cout;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (busy_cnt !== 8) begin
      errors++;
      $display("FAIL restart_busy_cycles: %0d, required 8", busy_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL restart_done_pulses: %0d, required 1", done_cnt);
    end
    checks++;
    if (got_sum !== 8'h46 || got_cout !== 1'b0) begin
      errors++;
      $display("FAIL restart_result: sum=%h cout=%b, required sum=46 cout=0", got_sum, got_cout);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    @(posedge clk); #1;
    op_a = 8'hC3; op_b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, cout, fa_a, fa_b, fa_cin} !== 14'd0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b done=%b sum=%h cout=%b fa=%b%b%b, required all 0",
               busy, done, sum, cout, fa_a, fa_b, fa_cin);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(8'hC3, 8'h5A, 1'b1, lat);
    checks++;
    if (lat !== 9 || sum !== 8'h1E || cout !== 1'b1) begin
      errors++;
      $display("FAIL midreset_fresh_op: lat=%0d sum=%h cout=%b, required lat=9 sum=1E cout=1", lat, sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    int cyc = 0;
    int last = -1;
    int got = 0;
    int idle = 0;
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    op_a = a; op_b = b; cin = c; start = 1'b1;
    exp = 9'(a) + 9'(b) + 9'(c);
    while (got < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        idle = 0;
        checks++;
        if ({cout, sum} !== exp) begin
          errors++;
          $display("FAIL b2b_result[%0d]: cout,sum=%h, required %h", got, {cout, sum}, exp);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 10) begin
            errors++;
            $display("FAIL b2b_period[%0d]: %0d cycles, required 10", got, cyc - last);
          end
        end
        last = cyc;
        got++;
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
        op_a = a; op_b = b; cin = c;
        exp = 9'(a) + 9'(b) + 9'(c);
      end else begin
        idle++;
        if (idle > 15) begin
          checks++;
          errors++;
          $display("FAIL b2b_timeout: no done after %0d cycles, op %0d", idle, got);
          break;
        end
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
